// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 7-segment digit scan scheduler
//
// Shares one BCD-to-7-segment decoder across DIGITS digits. Each digit gets
// GUARD_CYCLES blanked clocks followed by DWELL_CYCLES driven clocks. The
// displayed value is snapshotted once per frame so a frame is never torn.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         scan enable; 0 forces the display off and abandons the frame
//   lz_en      leading-zero suppression enable (used live)
//   value      packed BCD, digit k = value[4k+3:4k], k=0 rightmost
//   bcd        code to the shared decoder
//   an         one-hot digit enable, active-high
//   blank      1 = decoder output forced off
//   frame_tick one-cycle pulse in the last driven cycle of each frame

module seg_scan_ctrl #(
    parameter int DIGITS       = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  lz_en,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            bcd,
    output logic [DIGITS-1:0]     an,
    output logic                  blank,
    output logic                  frame_tick
);

    localparam int IW   = (DIGITS > 2) ? $clog2(DIGITS) : 1;
    localparam int TMAX = (DWELL_CYCLES > GUARD_CYCLES) ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [TW-1:0] GUARD_TOP = TW'(GUARD_CYCLES - 1);
    localparam logic [TW-1:0] DWELL_TOP = TW'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [IW-1:0]          idx, idx_n;
    logic [TW-1:0]          timer, timer_n;
    logic [4*DIGITS-1:0]    snapshot, snap_n;

    logic [3:0]             bcd_d;
    logic [DIGITS-1:0]      an_d;
    logic                   blank_d;
    logic                   tick_d;
    logic                   suppressed;
    logic                   upper_zero;

    // State and output registers. Outputs are computed from the next-state
    // values so they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            timer      <= '0;
            snapshot   <= '0;
            bcd        <= '0;
            an         <= '0;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            timer      <= timer_n;
            snapshot   <= snap_n;
            bcd        <= bcd_d;
            an         <= an_d;
            blank      <= blank_d;
            frame_tick <= tick_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        idx_n   = idx;
        timer_n = timer;
        snap_n  = snapshot;
        case (state)
            S_IDLE: begin
                if (en) begin
                    state_n = S_GUARD;
                    idx_n   = '0;
                    timer_n = GUARD_TOP;
                    snap_n  = value;
                end
            end
            S_GUARD: begin
                if (timer == '0) begin
                    state_n = S_DRIVE;
                    timer_n = DWELL_TOP;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            S_DRIVE: begin
                if (timer == '0) begin
                    state_n = S_GUARD;
                    timer_n = GUARD_TOP;
                    if (idx == LAST_IDX) begin
                        idx_n  = '0;
                        snap_n = value;
                    end else begin
                        idx_n = idx + IW'(1);
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                idx_n   = '0;
                timer_n = '0;
            end
        endcase
        // Dropping enable abandons the frame from any state.
        if (!en) begin
            state_n = S_IDLE;
            idx_n   = '0;
            timer_n = '0;
        end
    end

    // Output logic (registered above)
    always_comb begin
        // Walk from the most significant digit down so upper_zero covers
        // digits k..DIGITS-1 when digit k is reached.
        suppressed = 1'b0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (snap_n[4*k +: 4] == 4'h0);
            if (k == int'(idx_n)) begin
                suppressed = lz_en & upper_zero;
            end
        end

        bcd_d   = snap_n[4*int'(idx_n) +: 4];
        an_d    = '0;
        blank_d = 1'b1;
        if (state_n == S_DRIVE && !suppressed) begin
            an_d    = DIGITS'(1) << idx_n;
            blank_d = 1'b0;
        end
        tick_d = (state_n == S_DRIVE) && (timer_n == '0) && (idx_n == LAST_IDX);
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

    localparam int D     = 4;
    localparam int W     = 4;
    localparam int G     = 1;
    localparam int SLOT  = G + W;
    localparam int FRAME = D * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        lz_en;
    logic [15:0] value;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        blank;
    logic        frame_tick;

    int n_tests = 0;
    int n_fail  = 0;

    seg_scan_ctrl #(.DIGITS(D), .DWELL_CYCLES(W), .GUARD_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .value(value),
        .bcd(bcd), .an(an), .blank(blank), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the frame counted from the enable edge.
    bit          m_rst    = 1'b0;
    bit          m_active = 1'b0;
    bit          m_valid  = 1'b0;
    int          m_pos    = 0;
    logic [15:0] m_snap   = '0;
    bit          m_lz     = 1'b0;

    always @(posedge clk) begin
        m_valid = 1'b1;
        m_lz    = lz_en;
        m_rst   = rst;
        if (rst) begin
            m_active = 1'b0;
            m_snap   = '0;
        end else if (!en) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_snap   = value;
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == FRAME) begin
                m_pos  = 0;
                m_snap = value;
            end
        end
    end

    logic [3:0] prev_an = '0;

    always @(posedge clk) begin
        int d, off;
        logic [3:0] dig, e_an;
        logic [15:0] upper;
        bit sup;
        #1;
        if (m_valid) begin
            if (m_rst) begin
                chk("rst_an", an, 0);
                chk("rst_blank", blank, 1);
                chk("rst_bcd", bcd, 0);
                chk("rst_tick", frame_tick, 0);
            end else if (!m_active) begin
                chk("idle_an", an, 0);
                chk("idle_blank", blank, 1);
                chk("idle_tick", frame_tick, 0);
            end else begin
                d     = m_pos / SLOT;
                off   = m_pos % SLOT;
                dig   = m_snap[4*d +: 4];
                upper = m_snap >> (4*d);
                sup   = m_lz && (d != 0) && (upper == 16'h0);
                e_an  = (off < G || sup) ? 4'b0000 : (4'b0001 << d);
                chk("m_bcd", bcd, dig);
                chk("m_an", an, e_an);
                chk("m_blank", blank, (e_an == 4'b0000));
                chk("m_tick", frame_tick, (m_pos == FRAME - 1));
            end
            chk("inv_onehot", ($countones(an) <= 1), 1);
            chk("inv_blank_an0", (an == 4'b0000 && !blank), 0);
            chk("inv_gap", (an != 0 && prev_an != 0 && an != prev_an), 0);
            prev_an <= an;
        end
    end

    task automatic wait_tick(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_tick) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    task automatic wait_lit(input string name, input logic [3:0] a);
        bit seen = 1'b0;
        for (int i = 0; i < 3 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (an == a && !blank) seen = 1'b1;
        end
        chk(name, seen, 1);
    endtask

    // Counts lit cycles over the frame following a tick; expects the tick at the end.
    task automatic count_frame(input string name, input int exp_lit);
        int lit = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (an != 0) lit++;
            if (i == FRAME - 1) chk({name, "_tick"}, frame_tick, 1);
        end
        chk({name, "_lit"}, lit, exp_lit);
    endtask

    logic [3:0] an_lit  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] bcd_lit [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

    initial begin
        rst = 1'b1; en = 1'b1; lz_en = 1'b0; value = 16'h4321;
        // Reset with en held high
        repeat (3) begin
            @(negedge clk);
            chk("reset_an", an, 0);
            chk("reset_blank", blank, 1);
            chk("reset_bcd", bcd, 0);
            chk("reset_tick", frame_tick, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first_guard_an", an, 0);
        chk("first_guard_blank", blank, 1);
        chk("first_guard_bcd", bcd, 1);
        @(negedge clk);
        chk("first_drive_an", an, 4'b0001);
        chk("first_drive_blank", blank, 0);

        // Scan order, literal frame
        wait_tick("scan_tick_wait");
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i % SLOT == 0) begin
                chk("scan_guard_an", an, 0);
                chk("scan_guard_blank", blank, 1);
            end else begin
                chk("scan_an", an, an_lit[i / SLOT]);
                chk("scan_bcd", bcd, bcd_lit[i / SLOT]);
            end
            chk("scan_tick", frame_tick, (i == FRAME - 1));
        end

        // Leading-zero suppression
        lz_en = 1'b1; value = 16'h0005;
        wait_tick("lz5_tick_wait");
        count_frame("lz5", 4);
        value = 16'h0000;
        wait_tick("lz0_tick_wait");
        @(negedge clk);
        @(negedge clk);
        chk("lz0_digit0_an", an, 4'b0001);
        chk("lz0_digit0_bcd", bcd, 0);
        wait_tick("lz0_tick_wait2");
        value = 16'h0A00;
        wait_tick("lzA_tick_wait");
        count_frame("lzA", 12);

        // Mid-frame update
        lz_en = 1'b0; value = 16'h1111;
        wait_tick("mid_tick_wait");
        wait_lit("mid_digit1", 4'b0010);
        value = 16'h2222;
        wait_tick("mid_tick_wait2");
        chk("mid_old_bcd", bcd, 1);
        @(negedge clk);
        chk("mid_new_bcd", bcd, 2);

        // Enable drop during digit 2
        wait_lit("drop_digit2", 4'b0100);
        en = 1'b0;
        @(negedge clk);
        chk("drop_an", an, 0);
        chk("drop_blank", blank, 1);
        chk("drop_tick", frame_tick, 0);
        en = 1'b1;
        @(negedge clk);
        chk("reen_guard_an", an, 0);
        chk("reen_guard_blank", blank, 1);
        chk("reen_guard_bcd", bcd, 2);
        @(negedge clk);
        chk("reen_drive_an", an, 4'b0001);
        chk("reen_drive_blank", blank, 0);
        repeat (FRAME) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
